// File: rtl/matrix_mac_controller.sv
// matrix_mac_controller
// Job sequencer and round-robin arbiter in front of the shared 4x4 matrix MAC.
// One requester owns the MAC per job: the controller clears the accumulator,
// streams the owner's tile pairs through a valid/ready handshake (one MAC
// enable per accepted pair) and then holds the result until it is consumed.
// Operand data never passes through here; mac_sel steers an external mux.
//
// Handshake semantics (all channels): a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. Valid never depends on
// ready. req_ready and op_ready are driven from controller state plus the
// arbiter result; op_valid from non-owners is ignored.
module matrix_mac_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int TILE_CNT_W = 8,
  parameter int SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*TILE_CNT_W-1:0]  req_tiles,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             op_valid,
  output logic [NUM_REQ-1:0]             op_ready,
  output logic [SEL_W-1:0]               mac_sel,
  output logic                           mac_enable,
  output logic                           mac_clear,
  output logic                           res_valid,
  output logic [SEL_W-1:0]               res_owner,
  input  logic                           res_ready,
  output logic                           busy,
  output logic [1:0]                     dbg_state
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("matrix_mac_controller: NUM_REQ must be in 2..8");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("matrix_mac_controller: DATA_WIDTH must be at least 1");
  end
  if (TILE_CNT_W < 1) begin : g_bad_tile_w
    $error("matrix_mac_controller: TILE_CNT_W must be at least 1");
  end
  if (SEL_W < $clog2(NUM_REQ)) begin : g_bad_sel_w
    $error("matrix_mac_controller: SEL_W too narrow for NUM_REQ");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      owner_q, owner_d;
  logic [TILE_CNT_W-1:0] remain_q, remain_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [TILE_CNT_W-1:0] tiles_arr [NUM_REQ];
  logic                  grant_found;
  logic [SEL_W-1:0]      grant_idx;
  logic [SEL_W-1:0]      grant_next;
  logic                  owner_op_valid;

  // Unpack the flat tile-count bus into one count per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tiles_arr[i] = req_tiles[i*TILE_CNT_W +: TILE_CNT_W];
    end
  end

  // Round-robin pick: first pending requester at or after rr_ptr, with wrap.
  always_comb begin
    int               cand;
    logic [SEL_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = SEL_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Pointer value after a grant: the requester just past the winner.
  always_comb begin
    if (grant_idx == SEL_W'(NUM_REQ - 1)) begin
      grant_next = '0;
    end else begin
      grant_next = grant_idx + 1'b1;
    end
  end

  assign owner_op_valid = op_valid[owner_q];

  // Next-state, register updates and control outputs of the job sequencer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    remain_d   = remain_q;
    rr_ptr_d   = rr_ptr_q;
    req_ready  = '0;
    op_ready   = '0;
    mac_enable = 1'b0;
    mac_clear  = 1'b0;
    res_valid  = 1'b0;
    res_owner  = '0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          owner_d              = grant_idx;
          remain_d             = tiles_arr[grant_idx];
          rr_ptr_d             = grant_next;
          state_d              = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy      = 1'b1;
        mac_clear = 1'b1;
        // A zero-length job goes straight to DONE with a cleared result.
        state_d   = (remain_q == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        busy              = 1'b1;
        op_ready[owner_q] = 1'b1;
        mac_enable        = owner_op_valid;
        if (owner_op_valid) begin
          remain_d = remain_q - 1'b1;
          if (remain_q == TILE_CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_owner = owner_q;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The operand mux follows the owner and keeps its last value while idle.
  assign mac_sel   = owner_q;
  assign dbg_state = state_q;

  // State, owner, remaining count and round-robin pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      remain_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      remain_q <= remain_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Enable and clear must never overlap or the accumulator result is undefined.
  a_enable_clear_excl : assert property (
    @(posedge clock) disable iff (!reset) !(mac_enable && mac_clear));

  // Jobs are only accepted while idle.
  a_req_ready_idle : assert property (
    @(posedge clock) disable iff (!reset) (req_ready != '0) |-> !busy);

  // At most one requester is granted or served at a time.
  a_req_ready_onehot : assert property (
    @(posedge clock) disable iff (!reset) $onehot0(req_ready));

  a_op_ready_onehot : assert property (
    @(posedge clock) disable iff (!reset) $onehot0(op_ready));

endmodule

// File: tb/tb_matrix_mac_controller.sv
// Self-checking bench for matrix_mac_controller: directed job table,
// hand-written corner sequences, then randomized traffic against a
// transaction-level reference model with an expected-job queue.
module tb_matrix_mac_controller;

  localparam int NUM_REQ    = 2;
  localparam int TILE_CNT_W = 8;
  localparam int DATA_WIDTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_tiles = '0;
  logic [1:0]  req_ready;
  logic [1:0]  op_valid = '0;
  logic [1:0]  op_ready;
  logic [0:0]  mac_sel;
  logic        mac_enable;
  logic        mac_clear;
  logic        res_valid;
  logic [0:0]  res_owner;
  logic        res_ready = 1'b0;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  matrix_mac_controller #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REQ    (NUM_REQ),
    .TILE_CNT_W (TILE_CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_tiles  (req_tiles),
    .req_ready  (req_ready),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .mac_sel    (mac_sel),
    .mac_enable (mac_enable),
    .mac_clear  (mac_clear),
    .res_valid  (res_valid),
    .res_owner  (res_owner),
    .res_ready  (res_ready),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- behavioural MAC and operand sources ----------------
  int op_a [2][4][4];
  int op_b [2][4][4];
  int acc  [4][4];

  function automatic int prod_elem(input int r, input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += op_a[r][i][k] * op_b[r][k][j];
    return s;
  endfunction

  always @(posedge clock) begin
    if (mac_clear) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) acc[i][j] = 0;
    end else if (mac_enable) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) acc[i][j] = acc[i][j] + prod_elem(int'(mac_sel), i, j);
    end
  end

  task automatic set_identity();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          op_a[r][i][j] = (i == j) ? 1 : 0;
          op_b[r][i][j] = (i == j) ? 1 : 0;
        end
  endtask

  task automatic set_random_operands();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          op_a[r][i][j] = int'($urandom_range(0, 3));
          op_b[r][i][j] = int'($urandom_range(0, 3));
        end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic bit_at(input logic [1:0] v, input int i);
    return (i == 0) ? v[0] : v[1];
  endfunction

  function automatic logic [1:0] onehot(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic check_acc(input string tag, input int n, input int r);
    int rr;
    rr = (r < 0) ? 0 : r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s acc[%0d][%0d]", tag, i, j), acc[i][j], n * prod_elem(rr, i, j));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"},  req_ready,  0);
    check({tag, " op_ready"},   op_ready,   0);
    check({tag, " mac_sel"},    mac_sel,    0);
    check({tag, " mac_enable"}, mac_enable, 0);
    check({tag, " mac_clear"},  mac_clear,  0);
    check({tag, " res_valid"},  res_valid,  0);
    check({tag, " res_owner"},  res_owner,  0);
    check({tag, " busy"},       busy,       0);
  endtask

  // ---------------- driver: one complete job ----------------
  // Non-owner op_valid is held 1 throughout the job; the owner's op_valid
  // follows pat[k] for the k-th cycle after the clear cycle, then stays 1.
  task automatic do_job(input string tag, input logic [1:0] rv,
                        input logic [7:0] t0, input logic [7:0] t1,
                        input logic [7:0] pat, input int pat_len,
                        output int owner, output int lat, output int n_en);
    int  acc_c, n_clr, n_rv, n_rr, proto_bad, rown;
    bit  done;
    logic b;
    owner = -1; lat = -1; n_en = 0; n_clr = 0; n_rv = 0; n_rr = 0;
    proto_bad = 0; rown = -1; acc_c = -1; done = 0;
    for (int c = 0; c < 700 && !done; c++) begin
      @(negedge clock);
      req_valid = (acc_c < 0) ? rv : 2'b00;
      req_tiles = {t1, t0};
      res_ready = 1'b1;
      op_valid  = 2'b00;
      if (acc_c >= 0) begin
        op_valid = 2'b11;
        if (c - acc_c - 2 >= 0 && c - acc_c - 2 < pat_len) begin
          b = pat[3'(c - acc_c - 2)];
          if (owner == 0) op_valid[0] = b; else op_valid[1] = b;
        end
      end
      #1;
      if (req_ready != 2'b00) begin
        n_rr++;
        if (busy) proto_bad++;
        if (acc_c < 0) begin
          acc_c = c;
          owner = req_ready[1] ? 1 : 0;
        end
      end
      if (mac_enable && mac_clear) proto_bad++;
      if (acc_c >= 0 && c > acc_c && int'(mac_sel) != owner) proto_bad++;
      if (mac_enable) n_en++;
      if (mac_clear) n_clr++;
      if (res_valid) begin
        n_rv++;
        if (lat < 0) lat = c - acc_c;
        rown = int'(res_owner);
        if (res_ready) done = 1;
      end
    end
    check({tag, " job_completed"}, done, 1);
    check({tag, " req_ready_pulses"}, n_rr, 1);
    check({tag, " mac_clear_pulses"}, n_clr, 1);
    check({tag, " res_valid_cycles"}, n_rv, 1);
    check({tag, " res_owner"}, rown, owner);
    check({tag, " protocol_errors"}, proto_bad, 0);
    @(negedge clock);
    req_valid = 2'b00;
    op_valid  = 2'b00;
    #1;
    check({tag, " idle_after busy"}, busy, 0);
    check({tag, " idle_after res_valid"}, res_valid, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0] rv;
    logic [7:0] t0;
    logic [7:0] t1;
    int         exp_owner;
    int         exp_lat;
    int         exp_en;
  } vec_t;

  vec_t tbl [6];

  // random-phase model state
  logic [8:0] exp_q[$];
  int m_ptr, m_busy, cur_owner, en_cnt, clr_cnt;

  initial begin
    int owner, lat, n_en, grants, last_c, bad, drain_left;

    // Expected owners follow the round-robin pointer across the whole table.
    tbl[0] = '{2'b01, 8'd3, 8'd0,   0, 5,   3};
    tbl[1] = '{2'b11, 8'd1, 8'd1,   1, 3,   1};
    tbl[2] = '{2'b11, 8'd0, 8'd4,   0, 2,   0};
    tbl[3] = '{2'b01, 8'd2, 8'd0,   0, 4,   2};
    tbl[4] = '{2'b10, 8'd0, 8'd255, 1, 257, 255};
    tbl[5] = '{2'b10, 8'd0, 8'd1,   1, 3,   1};

    set_identity();

    // Reset state.
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Table-driven single jobs, no stalls, res_ready already high.
    for (int i = 0; i < 6; i++) begin
      do_job($sformatf("vec%0d", i), tbl[i].rv, tbl[i].t0, tbl[i].t1, 8'h00, 0,
             owner, lat, n_en);
      check($sformatf("vec%0d owner", i), owner, tbl[i].exp_owner);
      check($sformatf("vec%0d res_latency", i), lat, tbl[i].exp_lat);
      check($sformatf("vec%0d mac_enable_cycles", i), n_en, tbl[i].exp_en);
      check_acc($sformatf("vec%0d", i), tbl[i].exp_en, owner);
    end

    // Fairness: both requesters hold req_valid for 4 one-tile jobs.
    grants = 0; last_c = -1; bad = 0;
    for (int c = 0; c < 100 && grants < 4; c++) begin
      @(negedge clock);
      req_valid = 2'b11;
      req_tiles = {8'd1, 8'd1};
      op_valid  = 2'b11;
      res_ready = 1'b1;
      #1;
      if (req_ready != 2'b00) begin
        if (busy) bad++;
        check($sformatf("rr grant%0d", grants), req_ready, onehot(grants % 2));
        if (grants > 0) check($sformatf("rr spacing%0d", grants), c - last_c, 4);
        last_c = c;
        grants++;
      end
    end
    check("rr grant_count", grants, 4);
    drain_left = 20;
    do begin
      @(negedge clock);
      req_valid = 2'b00;
      #1;
      if (req_ready != 2'b00 && busy) bad++;
      drain_left--;
    end while (busy && drain_left > 0);
    check("rr drained", busy, 0);
    check("rr req_ready_while_busy", bad, 0);

    // Stalled job: owner op_valid 1,0,0,1 -> two stall cycles.
    do_job("stall", 2'b01, 8'd2, 8'd0, 8'b0000_1001, 4, owner, lat, n_en);
    check("stall owner", owner, 0);
    check("stall res_latency", lat, 6);
    check("stall mac_enable_cycles", n_en, 2);
    check_acc("stall", 2, 0);

    // Reset in ACCUM with 2 of 5 pairs left.
    n_en = 0; owner = -1;
    for (int c = 0; c < 30 && n_en < 3; c++) begin
      @(negedge clock);
      req_valid = (owner < 0) ? 2'b01 : 2'b00;
      req_tiles = {8'd0, 8'd5};
      op_valid  = 2'b11;
      res_ready = 1'b0;
      #1;
      if (req_ready != 2'b00) owner = req_ready[1] ? 1 : 0;
      if (mac_enable) n_en++;
    end
    check("midrst owner", owner, 0);
    check("midrst pairs_before_reset", n_en, 3);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clock);
    op_valid = 2'b00;
    @(negedge clock);
    reset = 1'b1;
    do_job("after_rst", 2'b11, 8'd1, 8'd1, 8'h00, 0, owner, lat, n_en);
    check("after_rst owner", owner, 0);
    check("after_rst res_latency", lat, 3);

    // Consumer stalls 10 cycles in DONE while a new request is pending.
    owner = -1; bad = 0;
    for (int c = 0; c < 30 && !res_valid; c++) begin
      @(negedge clock);
      req_valid = (owner < 0) ? 2'b01 : 2'b00;
      req_tiles = {8'd0, 8'd1};
      op_valid  = 2'b11;
      res_ready = 1'b0;
      #1;
      if (req_ready != 2'b00) owner = req_ready[1] ? 1 : 0;
    end
    check("hold reached_done", res_valid, 1);
    check("hold owner", owner, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      req_valid = 2'b11;
      res_ready = 1'b0;
      #1;
      check($sformatf("hold%0d res_valid", c), res_valid, 1);
      check($sformatf("hold%0d mac_enable", c), mac_enable, 0);
      check($sformatf("hold%0d req_ready", c), req_ready, 0);
      check($sformatf("hold%0d acc00", c), acc[0][0], 1);
    end
    @(negedge clock);
    req_valid = 2'b00;
    res_ready = 1'b1;
    #1;
    check("hold release res_valid", res_valid, 1);
    @(negedge clock);
    res_ready = 1'b0;
    #1;
    check("hold idle busy", busy, 0);
    check("hold idle res_valid", res_valid, 0);

    // ---------------- randomized traffic vs reference model ----------------
    @(negedge clock);
    reset = 1'b0;
    set_random_operands();
    @(negedge clock);
    reset = 1'b1;
    m_ptr = 0; m_busy = 0; cur_owner = 0; en_cnt = 0; clr_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 3300; c++) begin
      logic [1:0] exp_rr;
      logic [8:0] e;
      int         w;
      int         cand;
      int         next_busy;
      bit         drain;
      @(negedge clock);
      drain     = (c >= 3000);
      req_valid = drain ? 2'b00 : 2'($urandom_range(0, 3));
      req_tiles = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
      op_valid  = drain ? 2'b11 : 2'($urandom_range(0, 3));
      res_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      next_busy = m_busy;
      exp_rr    = 2'b00;
      w         = -1;
      if (!m_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = (m_ptr + k) % NUM_REQ;
          if (w < 0 && bit_at(req_valid, cand)) w = cand;
        end
      end
      if (w >= 0) exp_rr = onehot(w);
      check("rand req_ready", req_ready, exp_rr);
      check("rand busy", busy, m_busy);
      check("rand en_clr_excl", mac_enable && mac_clear, 0);
      if (m_busy) begin
        check("rand mac_sel", mac_sel, cur_owner);
        check("rand op_ready_other", op_ready & ~onehot(cur_owner), 0);
        check("rand enable_is_handshake", mac_enable,
              bit_at(op_valid, cur_owner) && bit_at(op_ready, cur_owner));
      end else begin
        check("rand idle op_ready", op_ready, 0);
        check("rand idle mac_enable", mac_enable, 0);
        check("rand idle res_valid", res_valid, 0);
      end
      if (mac_enable) en_cnt++;
      if (mac_clear) clr_cnt++;
      if (w >= 0) begin
        e = {1'(w), (w == 0) ? req_tiles[7:0] : req_tiles[15:8]};
        exp_q.push_back(e);
        m_ptr     = (w + 1) % NUM_REQ;
        cur_owner = w;
        en_cnt    = 0;
        clr_cnt   = 0;
        next_busy = 1;
      end
      if (res_valid && res_ready && m_busy) begin
        check("rand exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rand res_owner", res_owner, e[8]);
          check("rand pairs", en_cnt, e[7:0]);
          check("rand clears", clr_cnt, 1);
          check_acc("rand", int'(e[7:0]), int'(e[8]));
        end
        next_busy = 0;
      end
      m_busy = next_busy;
    end
    check("rand final exp_q_empty", exp_q.size(), 0);
    check("rand final busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
